// File: rtl/ccd_pkg.sv
// rtl/ccd_pkg.sv - shared types and constant helpers for the CCD frame packer
package ccd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_SOF,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pixel_word_packer.sv
// rtl/pixel_word_packer.sv - packs PIX_W pixels LSB-first into WORD_W words
module pixel_word_packer
    import ccd_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int WORD_W = 256
) (
    input  logic              pxlclk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              flush,
    input  logic [PIX_W-1:0]  pixel,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              pending,
    output logic              last_slot
);

    localparam int PPW    = WORD_W / PIX_W;
    localparam int FILL_W = (PPW > 1) ? clog2(PPW) : 1;

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_ins;
    logic [FILL_W-1:0] fill;

    assign pending   = (fill != '0);
    assign last_slot = (fill == FILL_W'(PPW - 1));

    always_comb begin
        acc_ins = acc;
        acc_ins[fill * PIX_W +: PIX_W] = pixel;
    end

    // acc is cleared after every emitted word, so a flushed word is zero-filled above the last pixel
    always_ff @(posedge pxlclk) begin
        if (!rst_n) begin
            acc        <= '0;
            fill       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                acc  <= '0;
                fill <= '0;
            end else if (push) begin
                if (last_slot) begin
                    word       <= acc_ins;
                    word_valid <= 1'b1;
                    acc        <= '0;
                    fill       <= '0;
                end else begin
                    acc  <= acc_ins;
                    fill <= fill + 1'b1;
                end
            end else if (flush && pending) begin
                word       <= acc;
                word_valid <= 1'b1;
                acc        <= '0;
                fill       <= '0;
            end
        end
    end

endmodule

// File: rtl/ccd_frame_packer.sv
// rtl/ccd_frame_packer.sv - captures one sensor frame per request into rotating DMEM buffers
module ccd_frame_packer
    import ccd_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int WORD_W  = 256,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int NUM_BUF = 2,
    parameter int ADDR_W  = 7,
    localparam int BUF_W  = (NUM_BUF > 1) ? clog2(NUM_BUF) : 1
) (
    input  logic              pxlclk,
    input  logic              rst_n,
    input  logic              iEnable,
    input  logic              iCont,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [PIX_W-1:0]  iDATA,
    output logic              oDone,
    output logic [BUF_W-1:0]  oBuf_idx,
    output logic              oShort,
    output logic              oOverrun,
    output logic [15:0]       oFrames,
    output logic              oWren,
    output logic [ADDR_W-1:0] oAddr,
    output logic [WORD_W-1:0] oData
);

    localparam int PPW  = WORD_W / PIX_W;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int WPF  = ceil_div(NPIX, PPW);
    localparam int PC_W = clog2(NPIX + 1);

    state_t            state;
    state_t            next_state;
    logic              cont_q;
    logic              tail_open;
    logic [PC_W-1:0]   pix_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic [BUF_W-1:0]  buf_ptr;
    logic [BUF_W-1:0]  buf_next;
    logic [ADDR_W-1:0] buf_base;
    logic              last_pixel;

    logic push;
    logic flush_req;
    logic pk_clear;
    logic emit;
    logic enter_done;
    logic pk_pending;
    logic pk_last;

    pixel_word_packer #(
        .PIX_W (PIX_W),
        .WORD_W(WORD_W)
    ) u_packer (
        .pxlclk    (pxlclk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .push      (push),
        .flush     (flush_req),
        .pixel     (iDATA),
        .word_valid(oWren),
        .word      (oData),
        .pending   (pk_pending),
        .last_slot (pk_last)
    );

    assign buf_base   = ADDR_W'(int'(buf_ptr) * WPF);
    assign buf_next   = (buf_ptr == BUF_W'(NUM_BUF - 1)) ? '0 : buf_ptr + 1'b1;
    assign last_pixel = (pix_cnt == PC_W'(NPIX - 1));
    assign emit       = (push && pk_last) || (flush_req && pk_pending);

    always_comb begin
        next_state = state;
        push       = 1'b0;
        flush_req  = 1'b0;
        pk_clear   = 1'b0;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                pk_clear = 1'b1;
                if (iEnable) next_state = SYNC;
            end
            SYNC: begin
                if (!iEnable)    next_state = IDLE;
                else if (!iFVAL) next_state = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!iEnable) begin
                    next_state = IDLE;
                end else if (iFVAL) begin
                    pk_clear   = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!iEnable) begin
                    pk_clear   = 1'b1;
                    next_state = IDLE;
                end else if (!iFVAL) begin
                    if (pk_pending) begin
                        next_state = FLUSH;
                    end else begin
                        next_state = DONE;
                        enter_done = 1'b1;
                    end
                end else if (iDVAL) begin
                    push = 1'b1;
                    if (last_pixel) begin
                        if (pk_last) begin
                            next_state = DONE;
                            enter_done = 1'b1;
                        end else begin
                            next_state = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!iEnable) begin
                    pk_clear   = 1'b1;
                    next_state = IDLE;
                end else begin
                    flush_req  = 1'b1;
                    next_state = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                if (cont_q)        next_state = SYNC;
                else if (!iEnable) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // tail_open marks the rest of a frame after its last accepted pixel, where extra pixels are overruns
    always_ff @(posedge pxlclk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cont_q    <= 1'b0;
            tail_open <= 1'b0;
            pix_cnt   <= '0;
            word_cnt  <= '0;
            buf_ptr   <= '0;
            oDone     <= 1'b0;
            oBuf_idx  <= '0;
            oShort    <= 1'b0;
            oOverrun  <= 1'b0;
            oFrames   <= '0;
            oAddr     <= '0;
        end else begin
            state <= next_state;

            if (emit) begin
                oAddr    <= buf_base + word_cnt;
                word_cnt <= word_cnt + 1'b1;
            end
            if (state == WAIT_SOF && next_state == CAPTURE) begin
                pix_cnt  <= '0;
                word_cnt <= '0;
            end
            if (push) pix_cnt <= pix_cnt + 1'b1;

            if (state == CAPTURE && iEnable && !iFVAL) oShort <= 1'b1;

            if (push && last_pixel) tail_open <= 1'b1;
            else if (!iFVAL)        tail_open <= 1'b0;
            if (tail_open && iFVAL && iDVAL) oOverrun <= 1'b1;

            if (enter_done) begin
                oDone    <= 1'b1;
                oBuf_idx <= buf_ptr;
                oFrames  <= oFrames + 1'b1;
                buf_ptr  <= buf_next;
            end
            if (state == DONE && next_state != DONE) oDone <= 1'b0;

            if (state == IDLE && next_state == SYNC) begin
                cont_q    <= iCont;
                oShort    <= 1'b0;
                oOverrun  <= 1'b0;
                tail_open <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ccd_frame_packer.md
Name: ccd_frame_packer

Overview:
Parametrised successor to the image-processing capture FSM.
- Accepts the down-sampled pixel stream (DVAL/DATA) qualified by the sensor frame-valid (FVAL).
- Packs pixels into WORD_W-bit DMEM words and writes one complete frame per CPU request.
- Supports configurable image size and pixel width, N rotating frame buffers, and a continuous mode with frame/error status.
- Sits between the crop-down stage and the DMEM 256-bit write port, in the pixel clock domain.

Parameters:
PIX_W, 8, bits per pixel
WORD_W, 256, DMEM word width; must be a multiple of PIX_W
IMG_W, 28, pixels per line after down-sampling
IMG_H, 28, lines per frame
NUM_BUF, 2, frame buffers in DMEM, laid out back to back from address 0
ADDR_W, 7, DMEM address width; NUM_BUF*WPF must be <= 2**ADDR_W
Derived (not overridable):
- PPW = WORD_W/PIX_W
- NPIX = IMG_W*IMG_H
- WPF = ceil(NPIX/PPW)
- BUF_W = max(1, clog2(NUM_BUF))

Ports:
pxlclk  in  1  pixel clock; the only clock
rst_n  in  1  synchronous active-low reset
iEnable  in  1  CPU capture request (level)
iCont  in  1  1 = continuous capture, 0 = single shot; sampled on leaving IDLE
iFVAL  in  1  registered sensor frame valid
iDVAL  in  1  pixel valid from crop-down stage
iDATA  in  PIX_W  pixel value
oDone  out  1  frame complete (level)
oBuf_idx  out  BUF_W  buffer holding the most recently completed frame
oShort  out  1  sticky: a frame ended with fewer than NPIX pixels
oOverrun  out  1  sticky: pixels beyond NPIX arrived in a frame
oFrames  out  16  completed-frame counter, wraps 0xFFFF -> 0
oWren  out  1  DMEM write strobe
oAddr  out  ADDR_W  DMEM write address
oData  out  WORD_W  DMEM write data

Behaviour:
Reset:
- rst_n=0 at a pxlclk edge puts the state in IDLE.
- All outputs go to 0, the partial word and pixel/word counters are cleared, and the write buffer pointer goes to 0.
- A reset mid-frame discards the partial word and issues no write.

States:
- IDLE: wait for iEnable=1. Latch iCont, then go to SYNC.
- SYNC: wait for iFVAL=0, so capture never starts mid-frame. Then go to WAIT_SOF.
- WAIT_SOF: wait for iFVAL=1. Clear pixel/word counters, then go to CAPTURE.
- CAPTURE:
  - Each cycle with iDVAL=1 and pixel count < NPIX places iDATA at bit slot [PIX_W*k +: PIX_W], where k = pixel count mod PPW (pixel 0 at the LSBs).
  - When slot PPW-1 is filled, the next cycle drives oWren=1 for exactly 1 cycle, with oAddr = buf*WPF + word and oData = the packed word. The word counter then increments.
  - iDVAL=1 at pixel count >= NPIX: the pixel is dropped and oOverrun is set.
  - Pixel count reaches NPIX and a partial word is pending: go to FLUSH.
  - Pixel count reaches NPIX and no partial word is pending: go to DONE.
  - iFVAL falls before NPIX pixels: set oShort, then go to FLUSH (if a partial word is pending) or DONE.
- FLUSH: write the partial word with unused upper slots zero-filled (1 cycle), then go to DONE.
  - NPIX=784, PPW=32 gives WPF=25; the last word carries 16 pixels plus 128 zero bits.
- DONE:
  - On entry: oBuf_idx <= buf, oFrames increments, oDone <= 1, and buf advances modulo NUM_BUF.
  - Single shot: hold oDone=1 until iEnable=0, then clear oDone and go to IDLE.
  - Continuous: clear oDone after 1 cycle, then go to SYNC.

Rules:
- iEnable=0 in any of SYNC, WAIT_SOF, CAPTURE or FLUSH aborts to IDLE.
  - No further writes are issued, and oDone and oFrames are unchanged.
  - buf does not advance.
- oShort and oOverrun clear only on reset or on an IDLE->SYNC transition.
- oWren, oAddr and oData are registered outputs.
- oData holds its last value when oWren=0. The write-data path has no reset requirement beyond the reset to 0.
- Only one write occurs per cycle. Word completion and FLUSH never overlap because FLUSH follows the final accepted pixel.

Decomposition:
Package ccd_pkg:
- state enum (IDLE, SYNC, WAIT_SOF, CAPTURE, FLUSH, DONE)
- function clog2
- function ceil_div
One sub-module, pixel_word_packer:
- Shift/slot register with a fill counter.
- Inputs: push, flush, pixel.
- Outputs: word_valid, word, pending.
- The FSM and address generation stay in the top level.

Test Plan:
- Defaults, single shot, full 784-pixel frame with pixel i = i[7:0]:
  - Expect 25 writes at addr 0..24.
  - Word 0 has bits [7:0]=0x00 and [255:248]=0x1F.
  - Word 24 upper 128 bits = 0.
  - Then oDone=1, oBuf_idx=0, oFrames=1.
- Enable asserted mid-frame (FVAL=1): no writes until FVAL falls and rises again; the capture then starts at pixel 0.
- Continuous mode, 3 frames:
  - Buffer bases are 0, 25, 0.
  - oBuf_idx is 0, 1, 0.
  - oDone pulses 1 cycle each.
  - oFrames=3.
- Short frame, FVAL drops after 40 pixels:
  - Two writes: word 0 holds pixels 0..31, word 1 holds pixels 32..39 plus zeros.
  - oShort=1 and oDone=1.
- Overrun: 800 pixels sent → 25 writes only, oOverrun=1, data matches the first 784 pixels.
- rst_n=0 for 1 cycle after 50 pixels:
  - All outputs 0, no write for the partial word.
  - A subsequent enable restarts at addr 0.
- Enable dropped during CAPTURE: go to IDLE, no further oWren, oFrames unchanged.
